psk_demod_stream: RTL and testbench
===================================

PSK_DEMOD_STREAM -- requirements
Module: psk_demod_stream

Interface
REQ-001 SHALL have parameter N, default 12: data bits per output word; N is even, 2 <= N <= 32.
REQ-002 SHALL have parameter ERR_W, default 16: erasure counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port qpsk_en, input, 1: 0 = BPSK (1 bit/symbol), 1 = QPSK (2 bits/symbol).
REQ-006 SHALL have port in_valid, input, 1: in_sym is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a symbol this cycle.
REQ-008 SHALL have port in_sym, input, 2: one 2-bit symbol code.
REQ-009 SHALL have port out_valid, output, 1: DataOut holds a complete word.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes DataOut this cycle.
REQ-011 SHALL have port DataOut, output, N: demodulated word; bit 0 = first bit demodulated.
REQ-012 SHALL have port err_clr, input, 1: clears err_cnt.
REQ-013 SHALL have port err_cnt, output, ERR_W: saturating count of BPSK erasures.

Function
REQ-014 SHALL accept a symbol only on a cycle with in_valid=1 and in_ready=1.
REQ-015 BPSK slice SHALL be: code 01 -> bit 0; any other code -> bit 1.
REQ-016 QPSK slice SHALL be: two bits per symbol, in_sym[0] at bit position k, in_sym[1] at position k+1.
REQ-017 Bits SHALL pack LSB-first into an N-bit accumulator with fill pointer 0..N-1.
REQ-018 qpsk_en SHALL be sampled only when the fill pointer is 0; a change mid-word SHALL be ignored until the next word starts.
REQ-019 Word structure SHALL be two stages: accumulator, then output register (DataOut, out_valid).
REQ-020 When the accumulator completes and the output register is empty, or is being consumed in the same cycle, the word SHALL move to DataOut with out_valid=1 on the next cycle; latency is one cycle after the last accepted symbol.
REQ-021 When the accumulator completes while the output register is held (out_valid=1, out_ready=0), acc_full SHALL be set and in_ready SHALL drop.
REQ-022 in_ready SHALL equal !acc_full.
REQ-023 When acc_full=1 and out_ready=1, the held word SHALL transfer to DataOut on that edge, acc_full SHALL clear, and in_ready SHALL return high on the next cycle.
REQ-024 out_valid SHALL clear after a handshake (out_valid & out_ready) unless a new word is transferred on the same edge.
REQ-025 DataOut SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 In BPSK mode, codes 00 and 11 SHALL increment err_cnt by 1 per accepted symbol.
REQ-027 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-028 QPSK symbols SHALL never count as erasures.
REQ-029 err_clr SHALL take priority over a same-cycle increment; the result is 0.
REQ-030 Full throughput SHALL be: one symbol per cycle with no bubbles while out_ready=1 continuously.

Reset
REQ-031 While rst_n=0 at a clock edge: fill pointer=0, acc_full=0, in_ready=1 (the cycle after reset release), out_valid=0, DataOut=0, err_cnt=0, latched mode=BPSK.
REQ-032 Reset mid-word SHALL discard the partial accumulator and any held word without emitting either.

Structure
REQ-033 Package psk_pkg SHALL hold: the symbol code constants (BPSK_NEG=2'b01), the mode enum (MODE_BPSK, MODE_QPSK), and the slicer function prototypes.
REQ-034 One combinational sub-module, psk_slicer, SHALL map (code, mode) to {bits[1:0], nbits, erasure}.
REQ-035 Sequential logic SHALL stay in psk_demod_stream.

Verification
REQ-036 BPSK, N=12, out_ready=1: 12 symbols alternating 01,10 -> DataOut=12'hAAA, out_valid for one cycle, one cycle after the 12th accept.
REQ-037 BPSK: symbols 00,11 plus 10 x code 01 -> DataOut=12'h003 and err_cnt=2; then err_clr pulse -> err_cnt=0.
REQ-038 QPSK: 6 symbols of 2'b10 -> DataOut=12'hAAA after 6 accepts; qpsk_en toggled after symbol 3 -> no effect on that word.
REQ-039 Backpressure: out_ready=0 for 30 cycles, 24+ symbols offered -> two words buffered, in_ready=0 after the 24th accept, DataOut stable; out_ready=1 -> both words delivered in order, in_ready=1 the cycle after the second transfer.
REQ-040 ERR_W=4: 20 BPSK symbols of code 00 -> err_cnt saturates at 15.
REQ-041 rst_n=0 after 5 symbols of a word -> out_valid=0, err_cnt=0; the next 12 symbols form a clean word with no leftover bits.

Source files
------------

// File: rtl/psk_pkg.sv
// Shared definitions for the PSK stream demodulator: symbol codes, mode enum
// and the per-symbol slicing rule used by psk_slicer.
package psk_pkg;

  localparam logic [1:0] BPSK_NEG  = 2'b01;
  localparam logic [1:0] BPSK_ERA0 = 2'b00;
  localparam logic [1:0] BPSK_ERA1 = 2'b11;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } mode_e;

  typedef struct packed {
    logic [1:0] bits;
    logic [1:0] nbits;
    logic       erasure;
  } slice_t;

  // BPSK: only the negative code gives 0; the two off-axis codes are erasures.
  function automatic slice_t slice_sym(input logic [1:0] code, input mode_e mode);
    slice_t s;
    s = '{bits: 2'b00, nbits: 2'd1, erasure: 1'b0};
    case (mode)
      MODE_QPSK: begin
        s.bits    = code;
        s.nbits   = 2'd2;
        s.erasure = 1'b0;
      end
      MODE_BPSK: begin
        s.bits    = {1'b0, (code != BPSK_NEG)};
        s.nbits   = 2'd1;
        s.erasure = (code == BPSK_ERA0) || (code == BPSK_ERA1);
      end
      default: begin
        s = '{bits: 2'b00, nbits: 2'd1, erasure: 1'b0};
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/psk_slicer.sv
// Combinational symbol slicer: maps one 2-bit code and the active mode to the
// demodulated bits, how many of them are valid, and an erasure flag.
module psk_slicer
  import psk_pkg::*;
(
  input  logic [1:0] code,
  input  logic       mode,
  output logic [1:0] bits,
  output logic [1:0] nbits,
  output logic       erasure
);

  slice_t slice_s;

  assign slice_s = slice_sym(code, mode_e'(mode));
  assign bits    = slice_s.bits;
  assign nbits   = slice_s.nbits;
  assign erasure = slice_s.erasure;

endmodule

// File: rtl/psk_demod_stream.sv
// Streaming BPSK/QPSK demodulator: packs sliced bits LSB-first into N-bit words
// through an accumulator plus output register, with a saturating erasure count.
module psk_demod_stream
  import psk_pkg::*;
#(
  parameter int N     = 12,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             qpsk_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     DataOut,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int PW = $clog2(N + 1);

  logic [PW-1:0]    fill_r;
  logic [N-1:0]     acc_r;
  logic [N-1:0]     dout_r;
  logic             acc_full_r;
  logic             out_valid_r;
  logic [ERR_W-1:0] err_r;
  mode_e            mode_r;

  mode_e            mode_s;
  logic [1:0]       bits_s;
  logic [1:0]       nbits_s;
  logic             erasure_s;
  logic [N-1:0]     ins_s;
  logic [N-1:0]     base_s;
  logic [N-1:0]     next_acc_s;
  logic [PW-1:0]    fill_next_s;
  logic             accept_s;
  logic             complete_s;
  logic             consume_s;

  psk_slicer u_slicer (
    .code    (in_sym),
    .mode    (mode_s),
    .bits    (bits_s),
    .nbits   (nbits_s),
    .erasure (erasure_s)
  );

  // Accept/complete decode; the mode is only re-sampled at a word boundary.
  always_comb begin
    mode_s      = mode_r;
    base_s      = acc_r;
    ins_s       = {N{1'b0}};
    accept_s    = in_valid & ~acc_full_r;
    consume_s   = out_valid_r & out_ready;
    if (fill_r == {PW{1'b0}}) begin
      mode_s = mode_e'(qpsk_en);
      base_s = {N{1'b0}};
    end else begin
      mode_s = mode_r;
      base_s = acc_r;
    end
    ins_s[1:0]  = bits_s;
    next_acc_s  = base_s | (ins_s << fill_r);
    fill_next_s = fill_r + PW'(nbits_s);
    complete_s  = accept_s && (fill_next_s == PW'(N));
  end

  // Accumulator, held-word flag and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_r      <= {PW{1'b0}};
      acc_r       <= {N{1'b0}};
      acc_full_r  <= 1'b0;
      out_valid_r <= 1'b0;
      dout_r      <= {N{1'b0}};
      mode_r      <= MODE_BPSK;
    end else begin
      // A held word (acc_full) always has priority over new input, which is blocked anyway.
      if (acc_full_r && out_ready) begin
        dout_r      <= acc_r;
        out_valid_r <= 1'b1;
      end else if (complete_s && (!out_valid_r || out_ready)) begin
        dout_r      <= next_acc_s;
        out_valid_r <= 1'b1;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      if (acc_full_r) begin
        acc_full_r <= ~out_ready;
      end else if (complete_s && out_valid_r && !out_ready) begin
        acc_full_r <= 1'b1;
      end else begin
        acc_full_r <= 1'b0;
      end

      if (accept_s) begin
        acc_r  <= next_acc_s;
        mode_r <= mode_s;
        if (complete_s) begin
          fill_r <= {PW{1'b0}};
        end else begin
          fill_r <= fill_next_s;
        end
      end else begin
        acc_r  <= acc_r;
        mode_r <= mode_r;
        fill_r <= fill_r;
      end
    end
  end

  // Saturating erasure counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= {ERR_W{1'b0}};
    end else if (err_clr) begin
      err_r <= {ERR_W{1'b0}};
    end else if (accept_s && erasure_s && (err_r != {ERR_W{1'b1}})) begin
      err_r <= err_r + ERR_W'(1);
    end else begin
      err_r <= err_r;
    end
  end

  assign in_ready  = ~acc_full_r;
  assign out_valid = out_valid_r;
  assign DataOut   = dout_r;
  assign err_cnt   = err_r;

endmodule

// File: tb/tb_psk_demod_stream.sv
// Self-checking bench: directed word table, backpressure/reset/saturation
// sequences, and randomized traffic against a word-level reference model.
module tb_psk_demod_stream;

  localparam int N       = 12;
  localparam int ERR_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        qpsk_en, in_valid, in_ready, out_valid, out_ready, err_clr;
  logic [1:0]  in_sym;
  logic [N-1:0] DataOut;
  logic [15:0] err_cnt;

  logic        in_valid4, in_ready4, out_valid4;
  logic [1:0]  in_sym4;
  logic [N-1:0] DataOut4;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int errors = 0;

  // reference model state: bits of the current word, queue of finished words
  int           m_cnt;
  logic [N-1:0] m_acc;
  logic         m_mode;
  logic [N-1:0] m_q[$];
  int           m_err;

  always #5 clk = ~clk;

  psk_demod_stream #(.N(N), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .qpsk_en(qpsk_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_sym(in_sym), .out_valid(out_valid),
    .out_ready(out_ready), .DataOut(DataOut), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  psk_demod_stream #(.N(N), .ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .qpsk_en(1'b0), .in_valid(in_valid4),
    .in_ready(in_ready4), .in_sym(in_sym4), .out_valid(out_valid4),
    .out_ready(1'b1), .DataOut(DataOut4), .err_clr(1'b0), .err_cnt(err_cnt4)
  );

  typedef struct {
    logic        qpsk;
    logic        toggle;
    int          nsym;
    logic [23:0] syms;
    logic [11:0] exp_word;
    logic [15:0] exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    logic acc_ok, era;
    if (!rst_n) begin
      m_cnt = 0; m_acc = '0; m_mode = 1'b0; m_q.delete(); m_err = 0;
    end else begin
      era    = 1'b0;
      acc_ok = in_valid && (m_q.size() < 2);
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc_ok) begin
        if (m_cnt == 0) m_mode = qpsk_en;
        if (m_mode) begin
          m_acc[m_cnt]     = in_sym[0];
          m_acc[m_cnt + 1] = in_sym[1];
          m_cnt += 2;
        end else begin
          m_acc[m_cnt] = (in_sym != 2'b01);
          era = (in_sym == 2'b00) || (in_sym == 2'b11);
          m_cnt += 1;
        end
        if (m_cnt == N) begin
          m_q.push_back(m_acc);
          m_cnt = 0;
          m_acc = '0;
        end
      end
      if (err_clr) m_err = 0;
      else if (era && m_err < ERR_MAX) m_err++;
    end
  endtask

  task automatic compare_model();
    chk("model_in_ready", in_ready, m_q.size() < 2);
    chk("model_out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("model_DataOut", DataOut, m_q[0]);
    chk("model_err_cnt", err_cnt, m_err);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  initial begin
    vec_t vt[8];
    vt[0] = '{1'b0, 1'b0, 12, 24'h999999, 12'hAAA, 16'd0};
    vt[1] = '{1'b0, 1'b0, 12, 24'h55555C, 12'h003, 16'd2};
    vt[2] = '{1'b1, 1'b0, 6,  24'h000AAA, 12'hAAA, 16'd0};
    vt[3] = '{1'b1, 1'b1, 6,  24'h000AAA, 12'hAAA, 16'd0};
    vt[4] = '{1'b0, 1'b1, 12, 24'hAAAAAA, 12'hFFF, 16'd0};
    vt[5] = '{1'b0, 1'b0, 12, 24'hFFFFFF, 12'hFFF, 16'd12};
    vt[6] = '{1'b0, 1'b0, 12, 24'h555555, 12'h000, 16'd0};
    vt[7] = '{1'b1, 1'b0, 6,  24'h0004E4, 12'h4E4, 16'd0};

    rst_n = 1'b0; qpsk_en = 1'b0; in_valid = 1'b0; in_sym = 2'b00;
    out_ready = 1'b1; err_clr = 1'b0; in_valid4 = 1'b0; in_sym4 = 2'b00;
    tick();
    tick();
    chk("rst_DataOut", DataOut, 12'h000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // narrow counter saturation
    in_valid4 = 1'b1; in_sym4 = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat4_14", err_cnt4, 4'd14);
    end
    chk("sat4_final", err_cnt4, 4'd15);
    in_valid4 = 1'b0;

    // directed word table
    for (int r = 0; r < 8; r++) begin
      out_ready = 1'b1; in_valid = 1'b0; err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("tbl_err_clr", err_cnt, 16'd0);
      qpsk_en = vt[r].qpsk;
      for (int i = 0; i < vt[r].nsym; i++) begin
        if (vt[r].toggle && i == 3) qpsk_en = ~qpsk_en;
        in_valid = 1'b1;
        in_sym   = vt[r].syms[2*i +: 2];
        tick();
        if (i == vt[r].nsym - 2) chk("tbl_early_valid", out_valid, 1'b0);
      end
      chk("tbl_out_valid", out_valid, 1'b1);
      chk("tbl_word", DataOut, vt[r].exp_word);
      in_valid = 1'b0;
      tick();
      chk("tbl_oneshot", out_valid, 1'b0);
      chk("tbl_err", err_cnt, vt[r].exp_err);
      qpsk_en = 1'b0;
    end

    // backpressure: two words buffered, then drained in order
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_sym = (c < 12) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b10;
      tick();
    end
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_valid_held", out_valid, 1'b1);
    chk("bp_first_word", DataOut, 12'hAAA);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_second_word", DataOut, 12'hFFF);
    chk("bp_second_valid", out_valid, 1'b1);
    chk("bp_in_ready_back", in_ready, 1'b1);
    tick();
    chk("bp_drained", out_valid, 1'b0);

    // reset mid-word discards partial bits and erasures
    in_valid = 1'b1; in_sym = 2'b00;
    repeat (5) tick();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_err", err_cnt, 16'd0);
    in_valid = 1'b1; in_sym = 2'b01;
    repeat (12) tick();
    chk("midrst_clean_valid", out_valid, 1'b1);
    chk("midrst_clean_word", DataOut, 12'h000);
    in_valid = 1'b0;
    tick();

    // randomized traffic; first stretch keeps out_ready high for full throughput
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      in_valid  = ($urandom_range(0, 3) != 0) || (c < 500);
      in_sym    = 2'($urandom_range(0, 3));
      qpsk_en   = 1'($urandom_range(0, 1));
      out_ready = (c < 500) ? 1'b1 : ($urandom_range(0, 9) < 7);
      err_clr   = ($urandom_range(0, 19) == 0);
      tick();
    end

    rst_n = 1'b1; in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
